// File: rtl/wb_retire_trace.sv
// Write-back retire tracer: captures each retiring MEM/WB instruction into a trace FIFO with retire/drop statistics.
// Build option: define TRACE_NOP_FILTER_EN to treat the canonical NOP (32'h00000013) as a bubble.
module wb_retire_trace #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wb_valid,
  input  logic [200:0]             wb_in,
  output logic                     tr_valid,
  input  logic                     tr_ready,
  output logic [31:0]              tr_pc,
  output logic [31:0]              tr_instr,
  output logic [4:0]               tr_rd,
  output logic [31:0]              tr_wdata,
  output logic                     tr_we,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // MEM/WB buffer layout, MSB first (mem_wb_reg, 201 bits)
  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic [1:0]  RWSel;
    logic [31:0] Pc_Imm;
    logic [31:0] Pc_Four;
    logic [31:0] Imm_Out;
    logic [31:0] Alu_Result;
    logic [31:0] MemReadData;
    logic [4:0]  rd;
    logic [31:0] Curr_Instr;
  } mem_wb_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        we;
  } rec_t;

  function automatic logic [31:0] wb_value(input mem_wb_t w);
    logic [31:0] v;
    v = w.Alu_Result;
    case (w.RWSel)
      2'b00:   v = w.MemtoReg ? w.MemReadData : w.Alu_Result;
      2'b01:   v = w.Pc_Four;
      2'b10:   v = w.Imm_Out;
      default: v = w.Pc_Imm;
    endcase
    return v;
  endfunction

  function automatic logic is_bubble(input logic [31:0] instr);
`ifdef TRACE_NOP_FILTER_EN
    return (instr == 32'h0) || (instr == 32'h0000_0013);
`else
    return (instr == 32'h0);
`endif
  endfunction

  mem_wb_t wb;
  rec_t    rec_new;
  rec_t    head;
  rec_t    mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic retire, full, push, pop, drop;

  assign wb = wb_in;

  always_comb begin
    rec_new       = '0;
    rec_new.pc    = wb.Pc_Four - 32'd4;
    rec_new.instr = wb.Curr_Instr;
    rec_new.rd    = wb.rd;
    rec_new.wdata = wb_value(wb);
    rec_new.we    = wb.RegWrite && (wb.rd != 5'd0);
  end

  // A full FIFO still accepts a record when the head leaves in the same cycle
  assign retire = wb_valid && !is_bubble(wb.Curr_Instr);
  assign full   = (level_q == LW'(DEPTH));
  assign pop    = tr_valid && tr_ready;
  assign push   = retire && (!full || pop);
  assign drop   = retire && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    retire_d = retire_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (retire) retire_d = retire_q + CNT_W'(1);
    if (drop) begin
      drop_d = drop_q + CNT_W'(1);
      ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      retire_q <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      retire_q <= retire_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; empty-state outputs are forced to zero below
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_new;
  end

  assign head     = mem_q[rd_ptr_q];
  assign tr_valid = (level_q != '0);
  assign tr_pc    = tr_valid ? head.pc    : 32'h0;
  assign tr_instr = tr_valid ? head.instr : 32'h0;
  assign tr_rd    = tr_valid ? head.rd    : 5'h0;
  assign tr_wdata = tr_valid ? head.wdata : 32'h0;
  assign tr_we    = tr_valid ? head.we    : 1'b0;

  assign retire_cnt = retire_q;
  assign drop_cnt   = drop_q;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_wb_retire_trace.sv
// Randomised + directed bench for wb_retire_trace against a queue-based reference model.
module tb_wb_retire_trace;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
`ifdef TRACE_NOP_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic [1:0]  RWSel;
    logic [31:0] Pc_Imm;
    logic [31:0] Pc_Four;
    logic [31:0] Imm_Out;
    logic [31:0] Alu_Result;
    logic [31:0] MemReadData;
    logic [4:0]  rd;
    logic [31:0] Curr_Instr;
  } wbf_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        we;
  } trec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wb_valid = 1'b0;
  logic tr_ready = 1'b0;
  wbf_t cur = '0;
  logic [200:0] wb_in;
  logic tr_valid, tr_we, overflow;
  logic [31:0] tr_pc, tr_instr, tr_wdata;
  logic [4:0] tr_rd;
  logic [CNT_W-1:0] retire_cnt, drop_cnt;
  logic [$clog2(DEPTH):0] fifo_level;

  assign wb_in = cur;
  always #5 clk = ~clk;

  wb_retire_trace #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_in(wb_in),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_instr(tr_instr),
    .tr_rd(tr_rd), .tr_wdata(tr_wdata), .tr_we(tr_we), .retire_cnt(retire_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow), .fifo_level(fifo_level)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of records plus counters
  trec_t       m_q[$];
  logic [31:0] m_ret = 0;
  logic [31:0] m_drop = 0;
  logic        m_ovf = 0;

  function automatic trec_t form(input wbf_t w);
    trec_t r;
    r.pc    = w.Pc_Four - 32'd4;
    r.instr = w.Curr_Instr;
    r.rd    = w.rd;
    r.we    = w.RegWrite && (w.rd != 0);
    if (w.RWSel == 2'd1)      r.wdata = w.Pc_Four;
    else if (w.RWSel == 2'd2) r.wdata = w.Imm_Out;
    else if (w.RWSel == 2'd3) r.wdata = w.Pc_Imm;
    else                      r.wdata = w.MemtoReg ? w.MemReadData : w.Alu_Result;
    return r;
  endfunction

  always @(negedge reset_n) begin
    m_q.delete();
    m_ret = 0; m_drop = 0; m_ovf = 0;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      bit ret, pop, was_full;
      ret = wb_valid && cur.Curr_Instr != 0 && !(FILT && cur.Curr_Instr == 32'h13);
      pop = (m_q.size() != 0) && tr_ready;
      was_full = (m_q.size() == DEPTH);
      if (ret) m_ret = m_ret + 1;
      if (pop) void'(m_q.pop_front());
      if (ret) begin
        if (!was_full || pop) m_q.push_back(form(cur));
        else begin m_drop = m_drop + 1; m_ovf = 1; end
      end
    end
  end

  always @(negedge clk) begin
    chk("tr_valid", tr_valid, m_q.size() != 0);
    chk("fifo_level", fifo_level, m_q.size());
    chk("retire_cnt", retire_cnt, m_ret);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("overflow", overflow, m_ovf);
    if (m_q.size() != 0) begin
      chk("tr_pc", tr_pc, m_q[0].pc);
      chk("tr_instr", tr_instr, m_q[0].instr);
      chk("tr_rd", tr_rd, m_q[0].rd);
      chk("tr_wdata", tr_wdata, m_q[0].wdata);
      chk("tr_we", tr_we, m_q[0].we);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input logic [31:0] instr, input logic [31:0] pc4, input logic [1:0] sel,
                     input logic m2r, input logic [31:0] alu, input logic [31:0] imm,
                     input logic [31:0] pcimm, input logic rw, input logic [4:0] rd);
    wb_valid         = 1'b1;
    cur.Curr_Instr   = instr;
    cur.Pc_Four      = pc4;
    cur.RWSel        = sel;
    cur.MemtoReg     = m2r;
    cur.Alu_Result   = alu;
    cur.MemReadData  = 32'hDEAD_BEEF;
    cur.Imm_Out      = imm;
    cur.Pc_Imm       = pcimm;
    cur.RegWrite     = rw;
    cur.rd           = rd;
  endtask

  task automatic drain();
    wb_valid = 1'b0;
    tr_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && fifo_level != 0; i++) step();
    tr_ready = 1'b0;
    chk("drain_empty", fifo_level, 0);
  endtask

  task automatic check_zero_state(input string tag);
    chk({tag, "_valid"}, tr_valid, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_ret"}, retire_cnt, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_pc"}, tr_pc, 0);
    chk({tag, "_instr"}, tr_instr, 0);
    chk({tag, "_wdata"}, tr_wdata, 0);
    chk({tag, "_we"}, tr_we, 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_zero_state("rst0");
    reset_n = 1'b1;

    // Basic addi x1,x0,5
    put(32'h0050_0093, 32'h14, 2'b00, 1'b0, 32'd5, 32'h0, 32'h0, 1'b1, 5'd1);
    step();
    wb_valid = 1'b0;
    chk("basic_valid", tr_valid, 1);
    chk("basic_pc", tr_pc, 32'h10);
    chk("basic_wdata", tr_wdata, 5);
    chk("basic_we", tr_we, 1);
    chk("basic_ret", retire_cnt, 1);
    drain();

    // Write-back source selection
    put(32'h0000_00EF, 32'h24, 2'b01, 1'b0, 32'h7, 32'hABCD_0000, 32'h100, 1'b1, 5'd3); step();
    put(32'hABCD_01B7, 32'h24, 2'b10, 1'b0, 32'h7, 32'hABCD_0000, 32'h100, 1'b1, 5'd3); step();
    put(32'h0000_0017, 32'h24, 2'b11, 1'b0, 32'h7, 32'hABCD_0000, 32'h100, 1'b1, 5'd0); step();
    wb_valid = 1'b0;
    chk("sel01_wdata", tr_wdata, 32'h24);
    chk("sel01_pc", tr_pc, 32'h20);
    tr_ready = 1'b1; step(); tr_ready = 1'b0;
    chk("sel10_wdata", tr_wdata, 32'hABCD_0000);
    tr_ready = 1'b1; step(); tr_ready = 1'b0;
    chk("sel11_wdata", tr_wdata, 32'h100);
    chk("rd0_we", tr_we, 0);
    drain();

    // Overflow: 10 retires into an 8-deep FIFO
    for (int i = 0; i < 10; i++) begin
      put(32'hA000_0000 + i, 32'h1000 + 4 * i, 2'b00, 1'b0, i, 32'h0, 32'h0, 1'b1, 5'd2);
      step();
    end
    wb_valid = 1'b0;
    chk("ovf_level", fifo_level, DEPTH);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_flag", overflow, 1);
    chk("ovf_ret", retire_cnt, 14);
    chk("ovf_head", tr_instr, 32'hA000_0000);

    // Full with simultaneous push and pop
    put(32'hB000_0000, 32'h2000, 2'b00, 1'b0, 32'h55, 32'h0, 32'h0, 1'b1, 5'd4);
    tr_ready = 1'b1;
    step();
    wb_valid = 1'b0; tr_ready = 1'b0;
    chk("fullpp_level", fifo_level, DEPTH);
    chk("fullpp_drop", drop_cnt, 2);
    chk("fullpp_head", tr_instr, 32'hA000_0001);
    drain();

    // Bubbles
    put(32'h0, 32'h3000, 2'b00, 1'b0, 32'h1, 32'h0, 32'h0, 1'b1, 5'd5); step();
    wb_valid = 1'b0;
    chk("bubble_ret", retire_cnt, 15);
    chk("bubble_level", fifo_level, 0);
    put(32'h0000_0013, 32'h3004, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0); step();
    wb_valid = 1'b0;
    chk("nop_ret", retire_cnt, FILT ? 15 : 16);
    chk("nop_level", fifo_level, FILT ? 0 : 1);
    drain();

    // Asynchronous reset while holding 3 records
    for (int i = 0; i < 3; i++) begin
      put(32'hC000_0000 + i, 32'h4000 + 4 * i, 2'b00, 1'b0, i, 32'h0, 32'h0, 1'b1, 5'd6);
      step();
    end
    wb_valid = 1'b0;
    chk("pre_rst_level", fifo_level, 3);
    #2 reset_n = 1'b0;
    #1 check_zero_state("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      int k;
      wbf_t w;
      w = '0;
      k = $urandom_range(0, 7);
      w.Curr_Instr  = (k == 0) ? 32'h0 : (k == 1) ? 32'h13 : ($urandom() | 32'h1);
      w.Pc_Four     = $urandom();
      w.RWSel       = 2'($urandom_range(0, 3));
      w.MemtoReg    = 1'($urandom_range(0, 1));
      w.Alu_Result  = $urandom();
      w.MemReadData = $urandom();
      w.Imm_Out     = $urandom();
      w.Pc_Imm      = $urandom();
      w.RegWrite    = 1'($urandom_range(0, 1));
      w.rd          = 5'($urandom_range(0, 31));
      cur      = w;
      wb_valid = ($urandom_range(0, 3) != 0);
      tr_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
